// File: rtl/count_n.sv
// Loadable up/down counter with runtime modulo limit, wrap or saturate at the
// boundaries, a registered terminal-count pulse and a sticky overflow flag.
module count_n #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dec,
    input  logic             set,
    input  logic [WIDTH-1:0] set_count,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_load_value;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_saturate;

    assign w_saturate   = (SATURATE != 0);
    assign w_load_value = (set_count > limit) ? limit : set_count;
    // ">=" so a count left above a lowered limit still takes the boundary rule on an up-step.
    assign w_at_top     = (r_count >= limit);
    assign w_at_bottom  = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (set) begin
            r_count <= w_load_value;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (en) begin
            if (!dec) begin
                if (w_at_top) begin
                    r_count <= w_saturate ? limit : '0;
                    r_tc    <= 1'b1;
                    r_ovf   <= 1'b1;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                    r_tc    <= 1'b0;
                end
            end else begin
                if (w_at_bottom) begin
                    r_count <= w_saturate ? '0 : limit;
                    r_tc    <= 1'b1;
                    r_ovf   <= 1'b1;
                end else begin
                    r_count <= r_count - WIDTH'(1);
                    r_tc    <= 1'b0;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
